// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU control codes and the controller state type
// for the multicycle MIPS control path.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // aluop selects between fixed add/sub and decoding the R-type funct field
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } ctrl_state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decode: fixed add/sub, or R-type funct lookup with a
// flag for funct codes the ALU does not implement.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] aluctrl,
    output logic       funct_bad
);

    always_comb begin
        aluctrl   = ALU_ADD;
        funct_bad = 1'b0;
        case (aluop)
            ALUOP_SUB: aluctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   aluctrl = ALU_ADD;
                    F_SUB:   aluctrl = ALU_SUB;
                    F_AND:   aluctrl = ALU_AND;
                    F_OR:    aluctrl = ALU_OR;
                    F_SLT:   aluctrl = ALU_SLT;
                    default: funct_bad = 1'b1;
                endcase
            end
            default: aluctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: Moore FSM driving datapath enables and muxes, with
// combinational ALU decode and branch-qualified PC enable.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluCtrl,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    ctrl_state_t state, state_next;
    logic        funct_bad_q;
    logic [1:0]  aluop;
    logic        funct_bad;
    logic        pcwrite, branch;
    logic        memwrite_s, irwrite_s, regwrite_s, illegal_s;
    logic        is_mem, is_rtype, is_beq, is_addi, is_j, op_known;

    assign is_mem   = (op == OP_LW) || (op == OP_SW);
    assign is_rtype = (op == OP_RTYPE);
    assign is_beq   = (op == OP_BEQ);
    assign is_addi  = ENABLE_ADDI && (op == OP_ADDI);
    assign is_j     = ENABLE_J && (op == OP_J);
    assign op_known = is_mem || is_rtype || is_beq || is_addi || is_j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Remembers an unimplemented funct so the following write-back is suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct_bad_q <= 1'b0;
        end else if (state == RTYPEEX) begin
            funct_bad_q <= funct_bad;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH: state_next = DECODE;
            DECODE: begin
                if (is_mem)        state_next = MEMADR;
                else if (is_rtype) state_next = RTYPEEX;
                else if (is_beq)   state_next = BEQEX;
                else if (is_addi)  state_next = ADDIEX;
                else if (is_j)     state_next = JEX;
                else               state_next = FETCH;
            end
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = MEMWB;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    // Mux defaults match FETCH so that unused encodings present FETCH values with no writes
    always_comb begin
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b01;
        aluop      = ALUOP_ADD;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_s  = 1'b0;
        case (state)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE: begin
                alusrcb   = 2'b11;
                illegal_s = !op_known;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b00;
                aluop     = ALUOP_FUNCT;
                illegal_s = funct_bad;
            end
            RTYPEWB: begin
                regwrite_s = !funct_bad_q;
                regdst     = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite_s = 1'b1;
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: irwrite_s = 1'b0;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .aluop     (aluop),
        .funct     (funct),
        .aluctrl   (aluCtrl),
        .funct_bad (funct_bad)
    );

    // Enables are qualified by rst_n so they drop the instant reset asserts
    assign memwrite   = rst_n && memwrite_s;
    assign irwrite    = rst_n && irwrite_s;
    assign regwrite   = rst_n && regwrite_s;
    assign illegal_op = rst_n && illegal_s;
    assign pcen       = rst_n && (pcwrite || (branch && zero));
    assign state_dbg  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: the driver pushes per-cycle expected control
// words into a queue, a monitor pops and compares them against the DUT outputs.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic [5:0] op = OP_RTYPE;
    logic [5:0] op_b = OP_RTYPE;
    logic [5:0] funct = F_ADD;
    logic       zero = 1'b0;

    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctrl;
    logic [3:0] state_dbg;

    logic       iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b, pcen_b, illegal_op_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [2:0] aluctrl_b;
    logic [3:0] state_dbg_b;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluCtrl(aluctrl), .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    mips_multicycle_ctrl #(.ENABLE_ADDI(1'b0), .ENABLE_J(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .op(op_b), .funct(funct), .zero(zero),
        .iord(iord_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .regdst(regdst_b),
        .memtoreg(memtoreg_b), .regwrite(regwrite_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
        .aluCtrl(aluctrl_b), .pcsrc(pcsrc_b), .pcen(pcen_b), .illegal_op(illegal_op_b),
        .state_dbg(state_dbg_b)
    );

    // clock block
    always #5 clk = ~clk;

    // Control word layout: state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    // alusrca, alusrcb, aluctrl, pcsrc, pcen, illegal_op
    localparam int W = 20;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    logic         sel_q[$];
    logic         chk_sel = 1'b0;
    int           checks = 0;
    int           errors = 0;
    event         sample_now;

    localparam logic [W-1:0] MW = {4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                   2'b00, 3'b000, 2'b00, 1'b1, 1'b1};

    function automatic logic [W-1:0] pk(input logic [3:0] st, input logic io, mw, irw, rd, m2r, rw, asa,
                                        input logic [1:0] asb, input logic [2:0] alu,
                                        input logic [1:0] pcs, input logic pe, ill);
        return {st, io, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pe, ill};
    endfunction

    // driver tasks
    task automatic push(input string nm, input logic [W-1:0] e, input logic [W-1:0] m);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(nm);
        sel_q.push_back(chk_sel);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] o);
        if (chk_sel) op_b = o;
        else         op = o;
    endtask

    task automatic e_fetch();
        push("fetch", pk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0),
             MW | pk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b11, 1'b0, 1'b0));
    endtask

    task automatic e_reset();
        push("reset", pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b11, 1'b0, 1'b0));
    endtask

    task automatic e_decode(input logic ill);
        push("decode", pk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0, ill),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b111, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_memadr();
        push("memadr", pk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_memrd();
        push("memrd", pk(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_memwb();
        push("memwb", pk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_memwr();
        push("memwr", pk(4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_rex(input logic [2:0] alu, input logic ill);
        push("rtypeex", pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, alu, 2'b00, 1'b0, ill),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_rwb(input logic rw);
        push("rtypewb", pk(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rw, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_beq(input logic z);
        push("beqex", pk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b011, 2'b01, z, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b11, 1'b0, 1'b0));
    endtask

    task automatic e_addiex();
        push("addiex", pk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_addiwb();
        push("addiwb", pk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic e_jex();
        push("jex", pk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0),
             MW | pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0));
    endtask

    // Instruction tasks start in a FETCH cycle and end in the next FETCH cycle (not yet pushed)
    task automatic run_lw();
        drive_op(OP_LW);
        e_fetch();  tick();
        e_decode(1'b0); tick();
        e_memadr(); tick();
        e_memrd();  tick();
        e_memwb();  tick();
    endtask

    task automatic run_sw();
        drive_op(OP_SW);
        e_fetch();  tick();
        e_decode(1'b0); tick();
        e_memadr(); tick();
        e_memwr();  tick();
    endtask

    task automatic run_r(input logic [5:0] f, input logic [2:0] alu, input logic bad);
        drive_op(OP_RTYPE);
        funct = f;
        e_fetch(); tick();
        e_decode(1'b0); tick();
        e_rex(alu, bad); tick();
        e_rwb(!bad); tick();
    endtask

    task automatic run_beq(input logic z);
        drive_op(OP_BEQ);
        zero = z;
        e_fetch(); tick();
        e_decode(1'b0); tick();
        e_beq(z); tick();
    endtask

    task automatic run_addi();
        drive_op(OP_ADDI);
        e_fetch();  tick();
        e_decode(1'b0); tick();
        e_addiex(); tick();
        e_addiwb(); tick();
    endtask

    task automatic run_j();
        drive_op(OP_J);
        e_fetch(); tick();
        e_decode(1'b0); tick();
        e_jex();   tick();
    endtask

    task automatic run_illegal(input logic [5:0] o);
        drive_op(o);
        e_fetch(); tick();
        e_decode(1'b1); tick();
    endtask

    // scoreboard monitor
    always begin
        logic [W-1:0] got, want, m;
        string        nm;
        logic         s;
        @(negedge clk or sample_now);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            m    = mask_q.pop_front();
            nm   = name_q.pop_front();
            s    = sel_q.pop_front();
            if (s)
                got = {state_dbg_b, iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b,
                       alusrca_b, alusrcb_b, aluctrl_b, pcsrc_b, pcen_b, illegal_op_b};
            else
                got = {state_dbg, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                       alusrca, alusrcb, aluctrl, pcsrc, pcen, illegal_op};
            checks++;
            if ((got & m) !== (want & m)) begin
                errors++;
                $display("FAIL %s dut%0d: got=%05h want=%05h mask=%05h (t=%0t)",
                         nm, s, got, want, m, $time);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        #2;
        e_reset(); ->sample_now;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;

        run_lw();
        run_sw();
        run_r(F_SLT, ALU_SLT, 1'b0);
        run_r(F_SUB, ALU_SUB, 1'b0);
        run_r(F_AND, ALU_AND, 1'b0);
        run_r(F_OR,  ALU_OR,  1'b0);
        run_r(F_ADD, ALU_ADD, 1'b0);
        run_beq(1'b1);
        run_beq(1'b0);
        run_addi();
        run_j();
        run_illegal(6'b111111);
        run_r(6'b000111, ALU_ADD, 1'b1);
        run_r(F_ADD, ALU_ADD, 1'b0);

        // asynchronous reset pulse in the middle of a store
        drive_op(OP_SW);
        e_fetch();  tick();
        e_decode(1'b0); tick();
        e_memadr(); tick();
        e_memwr();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        e_reset(); ->sample_now;
        #1;
        rst_n = 1'b1;
        #1;
        e_fetch(); ->sample_now;
        tick();
        e_decode(1'b0); tick();
        e_memadr(); tick();
        e_memwr();  tick();
        run_lw();

        // instance with addi and j disabled takes the illegal path for both
        chk_sel = 1'b1;
        rst_b_n = 1'b1;
        run_illegal(OP_J);
        run_illegal(OP_ADDI);
        run_beq(1'b1);
        e_fetch(); tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
